// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: instruction-memory request/response, decode back-pressure,
// redirect from later stages, and the fetch->decode bus.
interface fetch_stage_if #(
  parameter int FETCH_DECODE_BUS_WIDTH = 64
);
  logic                              req_valid_o;
  logic                              req_ready_i;
  logic [31:0]                       req_addr_o;
  logic                              resp_valid_i;
  logic [31:0]                       resp_data_i;
  logic                              stall_i;
  logic                              redirect_valid_i;
  logic [31:0]                       redirect_pc_i;
  logic                              fetch_valid_o;
  logic [FETCH_DECODE_BUS_WIDTH-1:0] fetch_decode_bus_o;

  modport master (
    output req_valid_o,
    input  req_ready_i,
    output req_addr_o,
    input  resp_valid_i,
    input  resp_data_i,
    input  stall_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output fetch_valid_o,
    output fetch_decode_bus_o
  );

  modport slave (
    input  req_valid_o,
    output req_ready_i,
    input  req_addr_o,
    output resp_valid_i,
    output resp_data_i,
    output stall_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  fetch_valid_o,
    input  fetch_decode_bus_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read at a time, delivers {pc, inst}
// to decode as a registered one-cycle pulse, honouring stall and redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_stage_if.master bus
);
  localparam int BUS_W = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_buf_q, inst_buf_d;
  logic             drop_q, drop_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic             req_valid;
  logic [31:0]      redirect_target;
  logic [31:0]      pc_plus4;

  assign redirect_target = bus.redirect_pc_i & 32'hFFFF_FFFC;
  assign pc_plus4        = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    inst_buf_d    = inst_buf_q;
    fetch_valid_d = 1'b0;
    bus_d         = bus_q;
    req_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (bus.redirect_valid_i) begin
          pc_d = redirect_target;
        end
      end
      S_REQ: begin
        req_valid = ~bus.redirect_valid_i;
        if (bus.redirect_valid_i) begin
          pc_d = redirect_target;
        end else if (bus.req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.resp_valid_i) begin
          // A pending drop means pc already holds the redirect target.
          if (drop_q || bus.redirect_valid_i) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (bus.redirect_valid_i) begin
              pc_d = redirect_target;
            end
          end else if (!bus.stall_i) begin
            fetch_valid_d = 1'b1;
            bus_d         = {pc_q, bus.resp_data_i};
            pc_d          = pc_plus4;
            state_d       = S_REQ;
          end else begin
            inst_buf_d = bus.resp_data_i;
            state_d    = S_HOLD;
          end
        end else if (bus.redirect_valid_i) begin
          pc_d   = redirect_target;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid_i) begin
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (!bus.stall_i) begin
          fetch_valid_d = 1'b1;
          bus_d         = {pc_q, inst_buf_q};
          pc_d          = pc_plus4;
          state_d       = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_buf_q    <= 32'd0;
      drop_q        <= 1'b0;
      fetch_valid_q <= 1'b0;
      bus_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_buf_q    <= inst_buf_d;
      drop_q        <= drop_d;
      fetch_valid_q <= fetch_valid_d;
      bus_q         <= bus_d;
    end
  end

  assign bus.req_valid_o        = req_valid;
  assign bus.req_addr_o         = pc_q;
  assign bus.fetch_valid_o      = fetch_valid_q;
  assign bus.fetch_decode_bus_o = bus_q;
endmodule
